// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    // Address width for a register count; usable in parameter defaults.
    function automatic int rf_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: bulk clear beats issue, issue beats write-clear.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = 8,
    parameter int AW       = rf_clog2(NREGS),
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_v,
    input  logic [AW-1:0]    clr_idx,
    input  logic             wr_a_v,
    input  logic [AW-1:0]    wr_a_addr,
    input  logic             wr_m_v,
    input  logic [AW-1:0]    wr_m_addr,
    input  logic             iss_v,
    input  logic [AW-1:0]    iss_a,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;
    logic             iss_ok_s;

    // Issues are dropped while clearing and, with a zero register, to r0.
    always_comb begin
        iss_ok_s = iss_v && !clr_v && !((ZERO_REG != 0) && (iss_a == {AW{1'b0}}));
    end

    // Next busy vector, evaluated bit by bit with the priority chain.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < NREGS; i++) begin
            if (((ZERO_REG != 0) && (i == 0)) || (clr_v && (clr_idx == AW'(i)))) begin
                busy_nxt_s[i] = 1'b0;
            end else if (iss_ok_s && (iss_a == AW'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if ((wr_a_v && (wr_a_addr == AW'(i))) || (wr_m_v && (wr_m_addr == AW'(i)))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
    end

    // Busy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {NREGS{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign busy = busy_r;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with data/move write ports,
// optional bypass and zero register, busy scoreboard and bulk-clear engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NREGS    = 8,
    parameter int AW       = rf_clog2(NREGS),
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NRD-1:0][AW-1:0]     ra,
    output logic [NRD-1:0][DATA_W-1:0] rd,
    output logic [NRD-1:0]             rd_busy,
    input  logic                       we_a,
    input  logic [AW-1:0]              wa_a,
    input  logic [DATA_W-1:0]          wd_a,
    input  logic                       we_m,
    input  logic [AW-1:0]              wa_m,
    input  logic [AW-1:0]              ms_m,
    input  logic                       iss_v,
    input  logic [AW-1:0]              iss_a,
    input  logic                       clr_req,
    output logic                       clr_busy,
    output logic                       clr_done,
    output logic [NREGS-1:0]           busy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    logic [DATA_W-1:0] rf_r [NREGS];
    rf_state_e         state_r;
    rf_state_e         state_nxt_s;
    logic [AW-1:0]     idx_r;
    logic [AW-1:0]     idx_nxt_s;
    logic              clearing_s;
    logic              a_ok_s;
    logic              m_ok_s;
    logic [NREGS-1:0]  busy_s;

    // Legal commits; port A wins a same-address collision with the move port.
    always_comb begin
        clearing_s = (state_r == RF_CLEAR);
        a_ok_s     = we_a && !clearing_s && !((ZERO_REG != 0) && (wa_a == {AW{1'b0}}));
        m_ok_s     = we_m && !clearing_s && !((ZERO_REG != 0) && (wa_m == {AW{1'b0}}))
                     && !(a_ok_s && (wa_a == wa_m));
    end

    // Clear engine next-state: one register per cycle, index wraps to zero.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            RF_IDLE: begin
                if (clr_req) begin
                    state_nxt_s = RF_CLEAR;
                    idx_nxt_s   = {AW{1'b0}};
                end else begin
                    state_nxt_s = RF_IDLE;
                end
            end
            RF_CLEAR: begin
                idx_nxt_s = idx_r + AW'(1);
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = RF_IDLE;
                end else begin
                    state_nxt_s = RF_CLEAR;
                end
            end
            default: begin
                state_nxt_s = RF_IDLE;
                idx_nxt_s   = {AW{1'b0}};
            end
        endcase
    end

    // Clear engine state and index registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= RF_IDLE;
            idx_r   <= {AW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    assign clr_busy = clearing_s;
    assign clr_done = clearing_s && (idx_r == LAST_IDX);

    // Data array; the move source is the pre-edge value of rf[ms_m].
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_r[i] <= {DATA_W{1'b0}};
            end
        end else if (clearing_s) begin
            rf_r[idx_r] <= {DATA_W{1'b0}};
        end else begin
            if (m_ok_s) begin
                rf_r[wa_m] <= rf_r[ms_m];
            end
            if (a_ok_s) begin
                rf_r[wa_a] <= wd_a;
            end
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (reset_n),
        .clr_v     (clearing_s),
        .clr_idx   (idx_r),
        .wr_a_v    (a_ok_s),
        .wr_a_addr (wa_a),
        .wr_m_v    (m_ok_s),
        .wr_m_addr (wa_m),
        .iss_v     (iss_v),
        .iss_a     (iss_a),
        .busy      (busy_s)
    );

    assign busy = busy_s;

    // Combinational read ports; a_ok_s is already low during a clear.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            if ((ZERO_REG != 0) && (ra[i] == {AW{1'b0}})) begin
                rd[i]      = {DATA_W{1'b0}};
                rd_busy[i] = 1'b0;
            end else if ((BYPASS != 0) && a_ok_s && (wa_a == ra[i])) begin
                rd[i]      = wd_a;
                rd_busy[i] = 1'b0;
            end else begin
                rd[i]      = rf_r[ra[i]];
                rd_busy[i] = busy_s[ra[i]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench: bypass, no-bypass and zero-register instances share stimulus.
module tb_regfile_mp;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [1:0][2:0] ra;
    logic            we_a, we_m, iss_v, clr_req;
    logic [2:0]      wa_a, wa_m, ms_m, iss_a;
    logic [7:0]      wd_a;

    logic [1:0][7:0] rd_b, rd_n, rd_z;
    logic [1:0]      rdb_b, rdb_n, rdb_z;
    logic            cb_b, cb_n, cb_z, cd_b, cd_n, cd_z;
    logic [7:0]      busy_b, busy_n, busy_z;

    int chk_cnt = 0;
    int err_cnt = 0;
    logic seen;

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .ra(ra), .rd(rd_b), .rd_busy(rdb_b),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_m(we_m), .wa_m(wa_m), .ms_m(ms_m),
        .iss_v(iss_v), .iss_a(iss_a), .clr_req(clr_req),
        .clr_busy(cb_b), .clr_done(cd_b), .busy(busy_b));

    regfile_mp #(.BYPASS(0), .ZERO_REG(0)) dut_n (
        .clk(clk), .reset_n(reset_n), .ra(ra), .rd(rd_n), .rd_busy(rdb_n),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_m(we_m), .wa_m(wa_m), .ms_m(ms_m),
        .iss_v(iss_v), .iss_a(iss_a), .clr_req(clr_req),
        .clr_busy(cb_n), .clr_done(cd_n), .busy(busy_n));

    regfile_mp #(.BYPASS(1), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset_n(reset_n), .ra(ra), .rd(rd_z), .rd_busy(rdb_z),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_m(we_m), .wa_m(wa_m), .ms_m(ms_m),
        .iss_v(iss_v), .iss_a(iss_a), .clr_req(clr_req),
        .clr_busy(cb_z), .clr_done(cd_z), .busy(busy_z));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle();
        we_a = 1'b0; wa_a = 3'd0; wd_a = 8'h00;
        we_m = 1'b0; wa_m = 3'd0; ms_m = 3'd0;
        iss_v = 1'b0; iss_a = 3'd0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        we_a = 1'b1; wa_a = a; wd_a = d;
        tick();
        idle();
    endtask

    initial begin
        reset_n = 1'b0;
        clr_req = 1'b0;
        ra      = '0;
        idle();
        #3;
        check("rst_rd0", rd_b[0], 32'h0);
        check("rst_busy", busy_b, 32'h0);
        check("rst_clr_busy", cb_b, 32'h0);
        check("rst_clr_done", cd_b, 32'h0);
        #9 reset_n = 1'b1;
        tick();

        // write r3 and read it same cycle and next cycle
        we_a = 1'b1; wa_a = 3'd3; wd_a = 8'hA5; ra[0] = 3'd3;
        settle();
        check("byp_same_cycle", rd_b[0], 32'hA5);
        check("nobyp_same_cycle", rd_n[0], 32'h00);
        tick();
        idle();
        settle();
        check("byp_next_cycle", rd_b[0], 32'hA5);
        check("nobyp_next_cycle", rd_n[0], 32'hA5);

        // move reads the pre-edge source while port A overwrites it
        wr(3'd1, 8'h11);
        wr(3'd2, 8'h22);
        we_a = 1'b1; wa_a = 3'd1; wd_a = 8'h33;
        we_m = 1'b1; wa_m = 3'd2; ms_m = 3'd1;
        tick();
        idle();
        ra[0] = 3'd2; ra[1] = 3'd1;
        settle();
        check("move_dest_r2", rd_b[0], 32'h11);
        check("porta_r1", rd_b[1], 32'h33);

        // port A wins a collision with the move port
        wr(3'd0, 8'h01);
        we_a = 1'b1; wa_a = 3'd5; wd_a = 8'h7E;
        we_m = 1'b1; wa_m = 3'd5; ms_m = 3'd0;
        tick();
        idle();
        ra[0] = 3'd5;
        settle();
        check("collision_r5", rd_b[0], 32'h7E);

        // scoreboard issue, write-clear, issue-wins
        iss_v = 1'b1; iss_a = 3'd4;
        tick();
        idle();
        ra[0] = 3'd4;
        settle();
        check("iss_busy4", busy_b[4], 32'h1);
        check("iss_rd_busy", rdb_b[0], 32'h1);
        we_a = 1'b1; wa_a = 3'd4; wd_a = 8'h44;
        settle();
        check("byp_rd_busy", rdb_b[0], 32'h0);
        check("nobyp_rd_busy", rdb_n[0], 32'h1);
        tick();
        idle();
        settle();
        check("wr_clears_busy4", busy_b[4], 32'h0);
        we_a = 1'b1; wa_a = 3'd4; wd_a = 8'h45;
        iss_v = 1'b1; iss_a = 3'd4;
        tick();
        idle();
        settle();
        check("iss_wins_busy4", busy_b[4], 32'h1);

        // fill and mark everything busy, then bulk clear
        for (int i = 0; i < 8; i++) begin
            we_a = 1'b1; wa_a = 3'(i); wd_a = 8'hFF;
            iss_v = 1'b1; iss_a = 3'(i);
            tick();
        end
        idle();
        settle();
        check("all_busy", busy_b, 32'hFF);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        ra[0] = 3'd7; ra[1] = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                we_a = 1'b1; wa_a = 3'd0; wd_a = 8'hAB;
            end
            settle();
            check($sformatf("clr_busy_k%0d", k), cb_b, 32'h1);
            check($sformatf("clr_done_k%0d", k), cd_b, (k == 7) ? 32'h1 : 32'h0);
            if (k == 3) check("clr_live_read_r7", rd_b[0], 32'hFF);
            if (k == 7) check("clr_no_bypass_r0", rd_b[1], 32'h00);
            tick();
            idle();
        end
        settle();
        check("clr_busy_end", cb_b, 32'h0);
        check("clr_done_end", cd_b, 32'h0);
        check("clr_scoreboard", busy_b, 32'h0);
        for (int i = 0; i < 8; i++) begin
            ra[0] = 3'(i);
            #1;
            check($sformatf("clr_r%0d", i), rd_b[0], 32'h00);
        end

        // asynchronous reset in the middle of a clear
        tick();
        wr(3'd7, 8'hFF);
        ra[0] = 3'd7;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (3) tick();
        settle();
        check("abort_pre_busy", cb_b, 32'h1);
        check("abort_pre_r7", rd_b[0], 32'hFF);
        #2 reset_n = 1'b0;
        #1;
        check("abort_rd_zero", rd_b[0], 32'h00);
        check("abort_clr_busy", cb_b, 32'h0);
        check("abort_clr_done", cd_b, 32'h0);
        #2 reset_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            settle();
            seen = seen | cd_b | cb_b;
        end
        check("abort_stays_idle", seen, 32'h0);

        // zero register drops writes and issues to r0
        we_a = 1'b1; wa_a = 3'd0; wd_a = 8'h5A;
        iss_v = 1'b1; iss_a = 3'd0;
        tick();
        idle();
        ra[0] = 3'd0;
        settle();
        check("zreg_rd0", rd_z[0], 32'h00);
        check("zreg_busy0", busy_z[0], 32'h0);
        check("zreg_rd_busy0", rdb_z[0], 32'h0);
        check("nozreg_rd0", rd_b[0], 32'h5A);
        check("nozreg_busy0", busy_b[0], 32'h1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
